// File: rtl/pipe_hazard_unit_pkg.sv
// rtl/pipe_hazard_unit_pkg.sv - shared constants and helpers for the pipeline hazard unit
package pipe_hazard_unit_pkg;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Scoreboard entry layout, MSB first: {v, rd, load}
  localparam int SB_V_W    = 1;
  localparam int SB_LOAD_W = 1;

  function automatic int fsw_of(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic int sb_entry_w(input int reg_aw);
    return SB_V_W + reg_aw + SB_LOAD_W;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// rtl/pipe_hazard_unit_match.sv - youngest-first scoreboard search for one source register
module hazard_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int FSW    = fsw_of(STAGES),
  localparam int EW    = sb_entry_w(REG_AW)
) (
  input  logic [REG_AW-1:0]          src,
  input  logic                       used,
  input  logic [STAGES-1:0][EW-1:0]  sb,
  output logic                       hit,
  output logic [FSW-1:0]             index,
  output logic                       load
);

  // Walk from WB toward EX so the youngest (lowest k) match overwrites older ones.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    load  = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (used && sb[k][EW-1] && (sb[k][REG_AW:SB_LOAD_W] == src) && (src != '0)) begin
        hit   = 1'b1;
        index = FSW'(k + 1);
        load  = sb[k][0];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - scoreboard-based forwarding, stall, bubble and flush control
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter bit FWD_EN  = 1'b1,
  parameter int MUL_LAT = 4,
  parameter int FSW     = fsw_of(STAGES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_mul,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [FSW-1:0]    fwd_rs,
  output logic [FSW-1:0]    fwd_rt,
  output logic              mul_busy
);

  localparam int EW  = sb_entry_w(REG_AW);
  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [STAGES-1:0][EW-1:0] sb;
  logic [MCW-1:0]            mul_cnt;

  logic           rs_hit, rt_hit, rs_load, rt_load;
  logic [FSW-1:0] rs_idx, rt_idx;
  logic           busy_int, raw_haz;
  logic           stall_c, bubble_c, flush_c;

  hazard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .FSW(FSW)) u_match_rs (
    .src   (id_rs),
    .used  (id_rs_used),
    .sb    (sb),
    .hit   (rs_hit),
    .index (rs_idx),
    .load  (rs_load)
  );

  hazard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .FSW(FSW)) u_match_rt (
    .src   (id_rt),
    .used  (id_rt_used),
    .sb    (sb),
    .hit   (rt_hit),
    .index (rt_idx),
    .load  (rt_load)
  );

  assign busy_int = (mul_cnt != '0);

  // With forwarding only a load still in EX is unresolvable; without it any in-flight writer is.
  always_comb begin
    raw_haz = 1'b0;
    if (FWD_EN) begin
      raw_haz = (rs_hit && rs_load && (rs_idx == FSW'(STG_EX + 1))) ||
                (rt_hit && rt_load && (rt_idx == FSW'(STG_EX + 1)));
    end else begin
      raw_haz = rs_hit || rt_hit;
    end
  end

  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (busy_int) begin
      stall_c = 1'b1;
    end else if (ex_br_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (raw_haz) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the ID inputs.
  assign stall    = reset & stall_c;
  assign bubble   = reset & bubble_c;
  assign flush    = reset & flush_c;
  assign mul_busy = reset & busy_int;
  assign fwd_rs   = (reset && FWD_EN && rs_hit) ? rs_idx : '0;
  assign fwd_rt   = (reset && FWD_EN && rt_hit) ? rt_idx : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb      <= '0;
      mul_cnt <= '0;
    end else if (busy_int) begin
      mul_cnt <= mul_cnt - MCW'(1);
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[STG_EX] <= bubble_c ? '0 : {id_valid & id_wr, id_rd, id_load};
      if (id_valid && id_mul && !bubble_c) begin
        mul_cnt <= MCW'(MUL_LAT - 1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed vector bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_wr, id_load, id_mul, ex_br_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       d_stall, d_bubble, d_flush, d_busy;
  logic [1:0] d_frs, d_frt;
  logic       m_stall, m_bubble, m_flush, m_busy;
  logic [1:0] m_frs, m_frt;
  logic       n_stall, n_bubble, n_flush, n_busy;
  logic [2:0] n_frs, n_frt;

  pipe_hazard_unit u_dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_mul(id_mul), .ex_br_taken(ex_br_taken),
    .stall(d_stall), .bubble(d_bubble), .flush(d_flush),
    .fwd_rs(d_frs), .fwd_rt(d_frt), .mul_busy(d_busy)
  );

  pipe_hazard_unit #(.MUL_LAT(1)) u_dut_m1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_mul(id_mul), .ex_br_taken(ex_br_taken),
    .stall(m_stall), .bubble(m_bubble), .flush(m_flush),
    .fwd_rs(m_frs), .fwd_rt(m_frt), .mul_busy(m_busy)
  );

  pipe_hazard_unit #(.STAGES(4), .FWD_EN(1'b0)) u_dut_nf (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_mul(id_mul), .ex_br_taken(ex_br_taken),
    .stall(n_stall), .bubble(n_bubble), .flush(n_flush),
    .fwd_rs(n_frs), .fwd_rt(n_frt), .mul_busy(n_busy)
  );

  typedef struct {
    int rst, vld, rs, rsu, rt, rtu, rd, wr, ld, mul, br;
    int st, bu, fl, mb, frs, frt;
  } vec_t;

  vec_t vecs [17];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clock) begin
    if (reset) begin
      assert (!(ex_br_taken && d_busy)) else $error("branch taken while multiply busy");
    end
  end

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0d exp=%0d", nm, row, got, exp);
    end
  endtask

  task automatic put(input int vld, input int rs, input int rsu, input int rt, input int rtu,
                     input int rd, input int wr, input int ld, input int mul, input int br);
    id_valid    = vld[0];
    id_rs       = rs[4:0];
    id_rs_used  = rsu[0];
    id_rt       = rt[4:0];
    id_rt_used  = rtu[0];
    id_rd       = rd[4:0];
    id_wr       = wr[0];
    id_load     = ld[0];
    id_mul      = mul[0];
    ex_br_taken = br[0];
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst[0];
    put(v.vld, v.rs, v.rsu, v.rt, v.rtu, v.rd, v.wr, v.ld, v.mul, v.br);
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1;
    reset = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rst vld rs rsu rt rtu rd wr ld mul br   st bu fl mb frs frt
    vecs[0]  = '{0, 1,  3, 1,  3, 1,  3, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1,  1, 1,  2, 1,  3, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1,  3, 1,  4, 1,  6, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[4]  = '{1, 1,  3, 1,  0, 0,  0, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0};
    vecs[5]  = '{1, 1,  0, 1,  3, 1,  5, 1, 1, 0, 0,   0, 0, 0, 0, 0, 3};
    vecs[6]  = '{1, 1,  6, 1,  5, 1,  7, 1, 0, 0, 0,   1, 1, 0, 0, 3, 1};
    vecs[7]  = '{1, 1,  6, 1,  5, 1,  7, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2};
    vecs[8]  = '{1, 1,  7, 1,  0, 0,  9, 1, 1, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[9]  = '{1, 1,  9, 1,  0, 0, 10, 1, 0, 0, 1,   0, 1, 1, 0, 1, 0};
    vecs[10] = '{1, 1, 10, 1,  9, 1, 11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2};
    vecs[11] = '{1, 1, 11, 1,  0, 0, 12, 1, 0, 1, 0,   0, 0, 0, 0, 1, 0};
    vecs[12] = '{1, 1, 12, 1, 11, 1, 13, 1, 0, 0, 0,   1, 0, 0, 1, 1, 2};
    vecs[13] = '{1, 1, 12, 1, 11, 1, 13, 1, 0, 0, 0,   1, 0, 0, 1, 1, 2};
    vecs[14] = '{1, 1, 12, 1, 11, 1, 13, 1, 0, 0, 0,   1, 0, 0, 1, 1, 2};
    vecs[15] = '{1, 1, 12, 1, 11, 1, 13, 1, 0, 0, 0,   0, 0, 0, 0, 1, 2};
    vecs[16] = '{1, 0, 13, 1, 11, 1,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3};

    for (int i = 0; i < 17; i++) begin
      @(posedge clock); #1;
      drive(vecs[i]);
      @(negedge clock);
      chk("stall",    i, 32'(d_stall),  vecs[i].st);
      chk("bubble",   i, 32'(d_bubble), vecs[i].bu);
      chk("flush",    i, 32'(d_flush),  vecs[i].fl);
      chk("mul_busy", i, 32'(d_busy),   vecs[i].mb);
      chk("fwd_rs",   i, 32'(d_frs),    vecs[i].frs);
      chk("fwd_rt",   i, 32'(d_frt),    vecs[i].frt);
      if (i >= 11) begin
        chk("m1_busy",  i, 32'(m_busy),  0);
        chk("m1_stall", i, 32'(m_stall), 0);
      end
    end

    // No forwarding, four stages: producer of $7 must fully retire before its consumer issues.
    reset_pulse();
    put(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    @(negedge clock); chk("nf_prod_stall", 100, 32'(n_stall), 0);
    @(posedge clock); #1; put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1; put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      put(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
      @(negedge clock);
      chk("nf_raw_stall",  101 + c, 32'(n_stall),  (c < 2) ? 1 : 0);
      chk("nf_raw_bubble", 101 + c, 32'(n_bubble), (c < 2) ? 1 : 0);
      chk("nf_fwd_rs",     101 + c, 32'(n_frs),    0);
    end
    @(posedge clock); #1; put(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clock); chk("nf_zero_wr_stall", 104, 32'(n_stall), 0);
    @(posedge clock); #1; put(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    @(negedge clock);
    chk("nf_zero_rd_stall", 105, 32'(n_stall), 0);
    chk("nf_zero_rd_fwd",   105, 32'(n_frt),   0);

    // Reset asserted while the multiply counter sits at 2.
    reset_pulse();
    put(1, 0, 0, 0, 0, 12, 1, 0, 1, 0);
    @(negedge clock); chk("rm_issue_busy", 200, 32'(d_busy), 0);
    @(posedge clock); #1; put(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
    @(negedge clock); chk("rm_busy_cnt3", 201, 32'(d_busy), 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rm_busy_cnt2",  202, 32'(d_busy),  1);
    chk("rm_stall_cnt2", 202, 32'(d_stall), 1);
    chk("rm_fwd_cnt2",   202, 32'(d_frs),   1);
    #1 reset = 1'b0;
    #1;
    chk("rm_rst_busy",   203, 32'(d_busy),   0);
    chk("rm_rst_stall",  203, 32'(d_stall),  0);
    chk("rm_rst_bubble", 203, 32'(d_bubble), 0);
    chk("rm_rst_fwd",    203, 32'(d_frs),    0);
    #1 reset = 1'b1;
    #1;
    chk("rm_rel_busy",  204, 32'(d_busy),  0);
    chk("rm_rel_stall", 204, 32'(d_stall), 0);
    chk("rm_rel_fwd",   204, 32'(d_frs),   0);
    @(posedge clock); #1; put(1, 12, 1, 0, 0, 14, 1, 0, 0, 0);
    @(negedge clock);
    chk("rm_after_fwd",   205, 32'(d_frs),   0);
    chk("rm_after_stall", 205, 32'(d_stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the multistage MIPS pipeline. It keeps a small scoreboard of in-flight destination registers for the stages after ID, and from it produces forwarding selects, stalls and bubbles for load-use and multiply hazards, and flushes for taken branches. It sits between the controller and the data path's pipeline registers and replaces the fixed single-stage hazard logic.

## Interface

Parameters:
- REG_AW, 5, register-address width
- STAGES, 3, scoreboard depth: entries after ID (index 0 = EX … STAGES-1 = WB)
- FWD_EN, 1, 1 = forward from scoreboard stages; 0 = stall on any RAW match
- MUL_LAT, 4, EX occupancy of a multiply in cycles (≥1)
- FSW, $clog2(STAGES+1), forwarding-select width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_rs_used, id_rt_used  in  1  source is actually read
- id_rd  in  REG_AW  ID destination register
- id_wr  in  1  ID instruction writes a register
- id_load  in  1  ID instruction is a load
- id_mul  in  1  ID instruction is a multiply
- ex_br_taken  in  1  branch in EX resolved taken
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load a NOP into ID/EX
- flush  out  1  clear IF/ID
- fwd_rs, fwd_rt  out  FSW  0 = register file; k+1 = result bus of stage k
- mul_busy  out  1  multiply occupies EX

## Operation

- Scoreboard entry per stage: {v, rd, load}. An entry matches source s iff v, rd == s, rd != 0 and the source is used.
- Forwarding (FWD_EN=1): fwd_x = k+1 for the lowest matching k (youngest wins); 0 if there is no match.
- Load-use: a match at k=0 with load=1 raises stall and bubble for 1 cycle. Next cycle the load sits at k=1 and fwd selects 2.
- FWD_EN=0: any match at any k raises stall and bubble. fwd outputs stay 0.
- Multiply: when an id_mul instruction advances into EX, an internal counter loads MUL_LAT-1.
  - While the counter is nonzero: mul_busy=1, stall=1, and the scoreboard holds. Do not shift and do not insert.
  - The counter decrements each cycle. When it reaches 0, normal flow resumes.
  - MUL_LAT=1 never asserts mul_busy.
- Branch: ex_br_taken raises flush=1 and bubble=1. The ID instruction is killed and not inserted. RAW stall is suppressed that cycle.
- Priority: reset > mul_busy > ex_br_taken > RAW stall > normal advance. ex_br_taken cannot occur with mul_busy; the bench asserts this.
- Scoreboard update on clock:
  - Hold if mul_busy.
  - Otherwise shift toward WB, and entry 0 gets one of:
    - {id_valid & id_wr & ~bubble, id_rd, id_load} on normal advance;
    - v=0 on a bubble.
  - The WB entry drops off.
- The register file writes in the first half of the cycle. An entry leaving WB therefore needs no forwarding.

## Timing

- All outputs are combinational from the scoreboard, the counter and the ID/EX inputs. There are no registered outputs. The scoreboard and counter update on the rising clock edge.
- While reset=0: all entries v=0, counter=0, and stall, bubble, flush, mul_busy and fwd_* are forced to 0. The first edge after release sees an empty scoreboard.
- Reset asserted mid-multiply clears the counter immediately, without waiting for a clock edge.
- Load-use costs exactly 1 bubble. A multiply costs MUL_LAT-1 stall cycles. A taken branch costs 1 flushed slot plus 1 bubble.
- rd=0 never matches, including for loads.

## Structure

- Shared package/header holds:
  - stage-index constants (EX=0, MEM=1, WB=2);
  - FSW computation;
  - scoreboard-entry field widths.
- One sub-module, hazard_match: combinational priority search over STAGES entries for one source register, returning {hit, index, load}. It is instantiated twice, for rs and rt.
- Top level holds the scoreboard shift register, the multiply counter and the priority/output logic.

## Test plan

- ALU back-to-back: add $3 writes; the next instruction reads $3 as rs -> fwd_rs=1, no stall. One cycle later, reading $3 -> fwd_rs=2.
- Load-use: lw $5 then add reading $5 as rt -> stall=1, bubble=1 for exactly 1 cycle, then fwd_rt=2.
- Multiply, MUL_LAT=4: mul enters EX -> mul_busy=stall=1 for 3 cycles with the scoreboard frozen, then resumes. Repeat with MUL_LAT=1 -> no stall.
- Taken branch with a pending load-use in ID: ex_br_taken=1 -> flush=1, bubble=1, the ID instruction does not enter the scoreboard, and there is no extra stall.
- FWD_EN=0, STAGES=4: producer of $7 at k=2 with a consumer reading $7 -> stall until the entry leaves WB; fwd stays 0. A consumer reading $0 with a writer to $0 in flight -> no stall.
- Reset pulse at counter=2 during a multiply -> all outputs 0 immediately. After release, the scoreboard is empty and a dependent instruction sees fwd=0 with no stall.
